parity_serial_rx: RTL
=====================

// Module: parity_serial_rx
// PURPOSE
//  Serial frame receiver that checks XOR parity. It is the receive end of the team's parity-protected 1-wire link.
//  It oversamples rx_in and finds the start bit, then shifts in DATA_W bits LSB-first.
//  It XOR-accumulates the data bits, checks them against the received parity bit and presents the word with error flags.
//  It sits between the pad-level input and the word-level consumer logic.
// PARAMETERS
//  DATA_W      8  data bits per frame (1..16)
//  OVERSAMPLE  4  clk cycles per bit period (even, >=4)
//  PARITY_ODD  0  0 = even parity expected, 1 = odd parity expected
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       asynchronous reset, active-high
//  rx_in       in   1       serial line; idle high
//  data_out    out  DATA_W  last received word; held until the next frame completes
//  valid_out   out  1       1-cycle pulse: data_out/parity_err/frame_err updated
//  parity_err  out  1       parity mismatch for the word at data_out
//  frame_err   out  1       stop bit sampled low (see CONFIGURATION)
//  busy        out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, sample counter=0, bit counter=0, parity accumulator=PARITY_ODD, sync flops=1.
//  rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s, so there are 2 cycles of fixed input latency.
//  Frame format: start(0), DATA_W data bits LSB-first, parity bit, stop(1).
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   rx_s==0 -> START, cnt<=0.
//   START:  at cnt==OVERSAMPLE/2-1, sample rx_s.
//           - If 0: go to DATA, cnt<=0.
//           - If 1: glitch; go to IDLE with no output.
//   DATA:   sample at cnt==OVERSAMPLE-1, i.e. mid-bit, every OVERSAMPLE cycles.
//           shift<={rx_s,shift[DATA_W-1:1]}; acc<=acc^rx_s.
//           After DATA_W samples -> PARITY.
//   PARITY: sample at cnt==OVERSAMPLE-1; perr<=acc^rx_s; -> STOP.
//   STOP:   sample at cnt==OVERSAMPLE-1.
//           Next cycle: data_out<=shift, parity_err<=perr, frame_err per macro, valid_out=1; -> IDLE.
//  cnt wraps to 0 at each sample point. The bit counter is log2(DATA_W+1) wide and wraps to 0 on leaving DATA.
//  Latency: valid_out rises 1 cycle after the stop-bit sample point.
//  Back-to-back frames: a new start bit is detected in IDLE on the cycle after valid_out. No idle gap is required beyond the stop bit.
//  parity_err/frame_err are sticky only until the next valid_out; they are never cleared between frames.
//  A line held low after a frame causes a new frame, never a hang.
//  rst mid-frame: immediate abort, outputs return to reset values, no valid_out; the partial word is discarded.
// CONFIGURATION
//  PARITY_RX_FRAME_CHECK_EN
//   Defined: frame_err<=~rx_s at the stop-bit sample.
//   Undefined: the stop bit is sampled for timing only and frame_err is tied 0. The port is always present.
// STRUCTURE
//  Package parity_rx_pkg: state enum rx_state_t {IDLE,START,DATA,PARITY,STOP}, localparam IDLE_LEVEL=1'b1.
//  Sub-module parity_bit_accum:
//   - 1-bit XOR accumulator with clear (load PARITY_ODD) and enable inputs.
//   - Reusable by the matching transmitter.
//  Top holds the synchronizer, counters, FSM and output registers.
// TESTING
//  Default params throughout.
//  1. Frame 0xA5, parity 0, stop 1 -> data_out=0xA5, parity_err=0, frame_err=0, one valid_out pulse.
//  2. Frame 0x01, parity 0 -> data_out=0x01, parity_err=1; then PARITY_ODD=1 run with same frame -> parity_err=0.
//  3. rx_in low for 1 clk then high -> no valid_out, busy drops within OVERSAMPLE/2+3 cycles.
//  4. Frame 0x3C with stop bit 0:
//     - macro defined -> frame_err=1.
//     - macro undefined -> frame_err=0; data_out=0x3C in both cases.
//  5. Back-to-back frames 0xFF then 0x00, no gap -> two valid_out pulses, data 0xFF then 0x00, parity_err=0 both.
//  6. rst asserted mid-DATA of frame 0x55 -> all outputs 0 immediately.
//     Then a clean 0x12 frame -> data_out=0x12, one valid_out pulse.

Source files
------------

// File: rtl/parity_rx_pkg.sv
// Shared types for the parity-protected 1-wire receive path.
// Holds the receiver FSM state encoding and the line idle level.
package parity_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_bit_accum.sv
// 1-bit XOR parity accumulator with clear and enable.
// Ports: clk, rst (async, active-high), clr (load PARITY_ODD),
//        en (fold din into acc), din, acc (running parity).
module parity_bit_accum #(
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= PARITY_ODD;
        end else if (clr) begin
            acc <= PARITY_ODD;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/parity_serial_rx.sv
// Oversampling serial receiver: start, DATA_W bits LSB-first, parity, stop.
// Ports: clk, rst (async, active-high), rx_in (serial, idle high),
//        data_out, valid_out (1-cycle pulse), parity_err, frame_err, busy.
// Macro PARITY_RX_FRAME_CHECK_EN: when defined, frame_err reports a
// low stop bit; otherwise frame_err is tied 0.
module parity_serial_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    logic              rx_m;
    logic              rx_s;
    rx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W:0]   shift_in;
    logic              perr;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;
    logic              at_mid;

    // Two-flop synchronizer, reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= IDLE_LEVEL;
            rx_s <= IDLE_LEVEL;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    assign at_mid   = (cnt == FULL);
    assign acc_clr  = (state == IDLE);
    assign acc_en   = (state == DATA) && at_mid;
    // Concatenate-then-drop keeps the shift legal for DATA_W == 1.
    assign shift_in = {rx_s, shift};
    assign busy     = (state != IDLE);

    parity_bit_accum #(
        .PARITY_ODD(PARITY_ODD != 0)
    ) u_accum (
        .clk(clk),
        .rst(rst),
        .clr(acc_clr),
        .en (acc_en),
        .din(rx_s),
        .acc(acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_s != IDLE_LEVEL) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        // A high line at mid start bit is a glitch.
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_mid) begin
                        cnt   <= '0;
                        shift <= shift_in[DATA_W:1];
                        if (bit_cnt == LAST) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (at_mid) begin
                        cnt   <= '0;
                        perr  <= acc ^ rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (at_mid) begin
                        cnt        <= '0;
                        data_out   <= shift;
                        parity_err <= perr;
`ifdef PARITY_RX_FRAME_CHECK_EN
                        frame_err  <= ~rx_s;
`else
                        frame_err  <= 1'b0;
`endif
                        valid_out  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
